// File: rtl/password_pkg.sv
`default_nettype none
// ============================================================================
// password_pkg : shared state encoding and default code for the lock blocks
// Revision     : 1.0
// ============================================================================
package password_pkg;

  localparam int DIGIT_W_DEF  = 4;
  localparam int N_DIGITS_DEF = 3;
  localparam logic [N_DIGITS_DEF*DIGIT_W_DEF-1:0] DEFAULT_CODE_DEF = 12'h371;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTER1 = 3'd1,
    ST_ENTER2 = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/onehot_press_det.sv
`default_nettype none
// ============================================================================
// onehot_press_det : rising-edge one-hot switch press detector and encoder
// Revision         : 1.0
// ============================================================================
module onehot_press_det
  import password_pkg::*;
#(
  parameter int SW_W    = 10,
  parameter int DIGIT_W = DIGIT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SW_W-1:0]    switches,
  output logic               press,
  output logic [DIGIT_W-1:0] digit
);

  logic [SW_W-1:0] sw_q;
  logic [SW_W-1:0] w_rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_q <= '0;
    end else begin
      sw_q <= switches;
    end
  end

  assign w_rise = switches & ~sw_q;
  // Exactly one rising bit: non-zero and a power of two.
  assign press  = (w_rise != '0) && ((w_rise & (w_rise - SW_W'(1))) == '0);

  always_comb begin
    digit = '0;
    for (int i = 0; i < SW_W; i++) begin
      if (w_rise[i]) digit = DIGIT_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/password_enroll.sv
`default_nettype none
// ============================================================================
// password_enroll : enters a new code twice and commits it when both match
// Revision        : 1.0
// ============================================================================
module password_enroll
  import password_pkg::*;
#(
  parameter int SW_W        = 10,
  parameter int DIGIT_W     = DIGIT_W_DEF,
  parameter int N_DIGITS    = N_DIGITS_DEF,
  parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = DEFAULT_CODE_DEF,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int ERR_HOLD    = 25_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SW_W-1:0]             switches,
  input  logic                        prog_req,
  input  logic                        unlocked,
  output logic [N_DIGITS*DIGIT_W-1:0] code,
  output logic                        code_updated,
  output logic                        busy,
  output logic                        err,
  output logic [1:0]                  digit_cnt,
  output logic [DIGIT_W-1:0]          disp_digit,
  output logic [SW_W-1:0]             led_out
);

  localparam int CNT_MAX = (TIMEOUT_CYC > ERR_HOLD) ? TIMEOUT_CYC : ERR_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STR_W   = $clog2(ERR_HOLD + 1);
  localparam logic [1:0] LAST_IDX = 2'(N_DIGITS - 1);

  state_t                            state_q, state_d;
  logic [1:0]                        idx_q, idx_d;
  logic [N_DIGITS-1:0][DIGIT_W-1:0]  digits_q, digits_d;
  logic                              match_q, match_d;
  logic [CNT_W-1:0]                  timer_q, timer_d;
  logic [N_DIGITS*DIGIT_W-1:0]       code_q, code_d;
  logic                              upd_q, upd_d;
  logic [DIGIT_W-1:0]                disp_q, disp_d;
  logic [STR_W-1:0]                  stretch_q, stretch_d;
  logic                              req_q;

  logic                              w_press;
  logic [DIGIT_W-1:0]                w_digit;
  logic                              w_req_rise;
  logic                              w_match;

  onehot_press_det #(
    .SW_W    (SW_W),
    .DIGIT_W (DIGIT_W)
  ) u_press_det (
    .clk      (clk),
    .rst      (rst),
    .switches (switches),
    .press    (w_press),
    .digit    (w_digit)
  );

  assign w_req_rise = prog_req & ~req_q;
  assign w_match    = match_q && (digits_q[idx_q] == w_digit);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      digits_q  <= '0;
      match_q   <= 1'b0;
      timer_q   <= '0;
      code_q    <= DEFAULT_CODE;
      upd_q     <= 1'b0;
      disp_q    <= '0;
      stretch_q <= '0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      digits_q  <= digits_d;
      match_q   <= match_d;
      timer_q   <= timer_d;
      code_q    <= code_d;
      upd_q     <= upd_d;
      disp_q    <= disp_d;
      stretch_q <= stretch_d;
      req_q     <= prog_req;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    digits_d  = digits_q;
    match_d   = match_q;
    timer_d   = timer_q;
    code_d    = code_q;
    upd_d     = 1'b0;
    disp_d    = disp_q;
    stretch_d = (stretch_q != '0) ? stretch_q - STR_W'(1) : '0;

    case (state_q)
      ST_IDLE: begin
        if (w_req_rise && unlocked) begin
          state_d  = ST_ENTER1;
          idx_d    = '0;
          digits_d = '0;
          timer_d  = '0;
          disp_d   = '0;
        end
      end

      ST_ENTER1, ST_ENTER2: begin
        // Lock loss and a repeated request abort even when a press coincides.
        if (!unlocked || w_req_rise) begin
          state_d = ST_ERROR;
          idx_d   = '0;
          timer_d = '0;
        end else if (w_press) begin
          timer_d = '0;
          if (state_q == ST_ENTER1) begin
            digits_d[idx_q] = w_digit;
            disp_d          = w_digit;
            if (idx_q == LAST_IDX) begin
              state_d = ST_ENTER2;
              idx_d   = '0;
              match_d = 1'b1;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            match_d = w_match;
            if (idx_q == LAST_IDX) begin
              state_d = w_match ? ST_COMMIT : ST_ERROR;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end else if (timer_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = ST_ERROR;
          idx_d   = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      ST_COMMIT: begin
        code_d    = digits_q;
        upd_d     = 1'b1;
        stretch_d = STR_W'(ERR_HOLD);
        state_d   = ST_IDLE;
      end

      ST_ERROR: begin
        if (timer_q == CNT_W'(ERR_HOLD - 1)) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  assign code         = code_q;
  assign code_updated = upd_q;
  assign busy         = (state_q == ST_ENTER1) || (state_q == ST_ENTER2) ||
                        (state_q == ST_COMMIT);
  assign err          = (state_q == ST_ERROR);
  assign digit_cnt    = idx_q;
  assign disp_digit   = disp_q;
  assign led_out      = {{(SW_W-4){1'b0}}, (stretch_q != '0), err,
                         (state_q == ST_ENTER2), (state_q == ST_ENTER1)};

endmodule
`default_nettype wire

// File: tb/tb_password_enroll.sv
`default_nettype none
// ============================================================================
// tb_password_enroll : directed self-checking bench for password_enroll
// Revision           : 1.0
// ============================================================================
module tb_password_enroll;

  localparam int SW_W = 10;

  logic            clk;
  logic            rst;
  logic [SW_W-1:0] switches;
  logic            prog_req;
  logic            unlocked;
  logic [11:0]     code;
  logic            code_updated;
  logic            busy;
  logic            err;
  logic [1:0]      digit_cnt;
  logic [3:0]      disp_digit;
  logic [SW_W-1:0] led_out;

  int errors = 0;
  int checks = 0;
  int n_err;

  password_enroll #(
    .SW_W        (SW_W),
    .DIGIT_W     (4),
    .N_DIGITS    (3),
    .DEFAULT_CODE(12'h371),
    .TIMEOUT_CYC (20),
    .ERR_HOLD    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .switches    (switches),
    .prog_req    (prog_req),
    .unlocked    (unlocked),
    .code        (code),
    .code_updated(code_updated),
    .busy        (busy),
    .err         (err),
    .digit_cnt   (digit_cnt),
    .disp_digit  (disp_digit),
    .led_out     (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int k);
    switches = SW_W'(1) << k;
    tick();
    switches = '0;
    tick();
  endtask

  task automatic start_prog();
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; switches = '0; prog_req = 1'b0; unlocked = 1'b0;

    // 1. reset
    tick(); tick();
    chk("rst_code", 32'(code), 32'h371);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_upd", 32'(code_updated), 32'd0);
    chk("rst_cnt", 32'(digit_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // 2. enroll 2,5,9 twice
    unlocked = 1'b1;
    start_prog();
    chk("e1_busy", 32'(busy), 32'd1);
    chk("e1_led", 32'(led_out), 32'h001);
    switches = SW_W'(1) << 2;
    tick();
    chk("e1_cnt1", 32'(digit_cnt), 32'd1);
    chk("e1_disp", 32'(disp_digit), 32'd2);
    switches = '0;
    tick();
    press(5); press(9);
    chk("e2_led", 32'(led_out), 32'h002);
    chk("e2_cnt0", 32'(digit_cnt), 32'd0);
    press(2); press(5);
    switches = SW_W'(1) << 9;
    tick();
    chk("commit_busy", 32'(busy), 32'd1);
    chk("commit_upd_early", 32'(code_updated), 32'd0);
    switches = '0;
    tick();
    chk("commit_code", 32'(code), 32'h952);
    chk("commit_upd", 32'(code_updated), 32'd1);
    chk("commit_idle", 32'(busy), 32'd0);
    chk("commit_led", 32'(led_out), 32'h008);
    tick();
    chk("upd_pulse", 32'(code_updated), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("stretch_last", 32'(led_out), 32'h008);
    tick();
    chk("stretch_end", 32'(led_out), 32'h000);

    // 3. mismatching second entry
    start_prog();
    press(4); press(4); press(0);
    press(4); press(4);
    switches = SW_W'(1) << 1;
    tick();
    chk("mm_err", 32'(err), 32'd1);
    chk("mm_led", 32'(led_out), 32'h004);
    switches = '0;
    n_err = 0;
    for (int i = 0; i < 20; i++) begin
      if (err) n_err++;
      tick();
    end
    chk("mm_hold", 32'(n_err), 32'd8);
    chk("mm_code", 32'(code), 32'h952);
    chk("mm_idle", 32'(busy), 32'd0);

    // 4. held switch and multi-bit rise, then 5a. timeout in ENTER1
    start_prog();
    switches = SW_W'(1) << 6;
    tick();
    chk("hold_cnt1", 32'(digit_cnt), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("hold_cnt_still1", 32'(digit_cnt), 32'd1);
    switches = '0;
    tick();
    switches = 10'b0000100100;
    tick();
    chk("multi_no_press", 32'(digit_cnt), 32'd1);
    switches = '0;
    tick();
    for (int i = 0; i < 12; i++) tick();
    chk("to_not_yet", 32'(err), 32'd0);
    tick();
    chk("to_err", 32'(err), 32'd1);
    chk("to_code", 32'(code), 32'h952);
    for (int i = 0; i < 8; i++) tick();
    chk("to_idle", 32'(busy | err), 32'd0);

    // press coinciding with timeout expiry wins; then prog_req rise aborts
    start_prog();
    for (int i = 0; i < 19; i++) tick();
    switches = SW_W'(1) << 3;
    tick();
    chk("to_press_wins", 32'(err), 32'd0);
    chk("to_press_cnt", 32'(digit_cnt), 32'd1);
    switches = '0;
    prog_req = 1'b1;
    tick();
    chk("req_abort", 32'(err), 32'd1);
    prog_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // 5b. unlocked falls in ENTER2
    start_prog();
    press(1); press(2); press(3); press(1);
    unlocked = 1'b0;
    tick();
    chk("unl_err", 32'(err), 32'd1);
    chk("unl_code", 32'(code), 32'h952);
    for (int i = 0; i < 8; i++) tick();
    unlocked = 1'b1;

    // 6. reset mid ENTER2, then request while locked
    start_prog();
    press(7); press(7); press(7); press(7);
    chk("pre_rst_cnt", 32'(digit_cnt), 32'd1);
    rst = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_code", 32'(code), 32'h371);
    chk("mid_rst_led", 32'(led_out), 32'd0);
    rst = 1'b1;
    unlocked = 1'b0;
    tick();
    prog_req = 1'b1;
    tick();
    chk("locked_req", 32'(busy), 32'd0);
    prog_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
